mac_accumulator: RTL and testbench
==================================

// Module: mac_accumulator
// PURPOSE
//  Downstream sequencer/accumulator for the shift-and-add multiplier in the MAC datapath.
//  Accepts operand pairs (valid/ready), drives the multiplier's LA/LB/s controls,
//  waits for Finish, then adds product P into a running accumulator.
//  Releases the multiplier back to its idle state. One product in flight at a time.
// PARAMETERS
//  N      32  operand width; must match multiplier n.
//  ACC_W  72  accumulator width; ACC_W >= 2*N is required.
//  CNT_W  8   width of the accumulated-product counter.
// PORTS
//  clk         in   1       rising-edge clock.
//  reset       in   1       synchronous, active-high reset. Same net also drives multiplier reset.
//  in_valid    in   1       operand pair valid.
//  in_ready    out  1       block can accept an operand pair.
//  in_a        in   N       multiplicand.
//  in_b        in   N       multiplier operand.
//  clear       in   1       synchronous accumulator clear.
//  mul_da      out  N       to multiplier DataA (registered operand A).
//  mul_db      out  N       to multiplier DataB (registered operand B).
//  mul_la      out  1       to multiplier LA.
//  mul_lb      out  1       to multiplier LB.
//  mul_s       out  1       to multiplier s (start/hold).
//  mul_p       in   2N      multiplier product P.
//  mul_finish  in   1       multiplier Finish.
//  acc         out  ACC_W   accumulator value (unsigned).
//  acc_count   out  CNT_W   number of products accumulated since clear; saturates at all-ones.
//  ovf         out  1       sticky flag: carry out of bit ACC_W-1 on any accumulate.
//  busy        out  1       high in every state except IDLE.
// BEHAVIOUR
//  Reset: state=IDLE; acc=0, acc_count=0, ovf=0; mul_la=mul_lb=mul_s=0; mul_da=mul_db=0.
//  All outputs are registered or decoded from the state register; nothing depends combinationally on inputs.
//  FSM:
//   IDLE: in_ready=1. On in_valid: latch in_a->mul_da and in_b->mul_db, then go to LOAD.
//   LOAD: mul_la=mul_lb=1 for exactly 1 cycle; mul_s=0. Go to RUN.
//   RUN: mul_s=1. Stay while mul_finish=0. On mul_finish=1, go to ACCUM.
//   ACCUM: mul_s=1 (holds P stable). Update acc, then go to RELEASE.
//     acc <= acc + {0,mul_p}, computed modulo 2^ACC_W.
//     acc_count <= acc_count+1, saturating.
//     ovf |= carry.
//   RELEASE: mul_s=0. Stay while mul_finish=1. Go to IDLE once mul_finish=0.
//  in_ready is 0 in every state except IDLE. mul_da/mul_db hold their value until the next accept.
//  clear: honoured in any state.
//   Outside ACCUM: acc=0, acc_count=0, ovf=0.
//   In ACCUM, clear overrides add: acc={0,mul_p}, acc_count=1, ovf=0.
//   clear together with an accept in IDLE: both take effect.
//  Latency: the accept edge is followed by at least 3 cycles (LOAD, RUN..., ACCUM) before acc updates.
//   acc changes on the edge after the first cycle mul_finish is sampled high.
//   in_ready returns 1 no earlier than 2 cycles after ACCUM.
//  Zero operand (in_b=0): multiplier finishes at once. Product 0 is added; acc_count still increments.
//  Reset mid-operation, any state: return to IDLE at once with reset values.
//   mul_s drops, so the multiplier (on the same reset) also returns to its idle state. No partial accumulate.
//  in_valid held through busy is ignored and is not lost (it is accepted in the next IDLE).
// TESTING
//  1. Reset, then a=3, b=5 -> one ACCUM; acc=15, acc_count=1, ovf=0; mul_la/mul_lb pulse exactly 1 cycle.
//  2. Then a=b=0xFFFFFFFF -> acc=0xFFFFFFFE00000010, acc_count=2.
//  3. a=0x1234, b=0 -> acc unchanged, acc_count+1; in_ready returns after RELEASE.
//  4. ACC_W=64: two products of 0xFFFFFFFF^2 -> acc=0xFFFFFFFC00000002, ovf=1.
//     Then clear -> acc=0, ovf=0.
//  5. Assert clear during the ACCUM of 7*6 with acc=100 -> acc=42, acc_count=1.
//  6. reset asserted mid-RUN -> next cycle IDLE, mul_s=0, acc=0.
//     A new accept of 2*2 then gives acc=4.

Source files
------------

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mac_accumulator
// Description : Sequencer and accumulator placed after a shift-and-add
//               multiplier. It accepts an operand pair, loads and starts the
//               multiplier, waits for Finish, adds the product into a running
//               sum and then releases the multiplier. Only one product is in
//               flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
  parameter int N     = 32,
  parameter int ACC_W = 72,   // must be >= 2*N
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             clear,
  output logic [N-1:0]     mul_da,
  output logic [N-1:0]     mul_db,
  output logic             mul_la,
  output logic             mul_lb,
  output logic             mul_s,
  input  logic [2*N-1:0]   mul_p,
  input  logic             mul_finish,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] acc_count,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_ACCUM   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       da_q, da_d;
  logic [N-1:0]       db_q, db_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  // One extra bit on top of the accumulator captures the carry for ovf.
  logic [ACC_W:0]     acc_sum;
  assign acc_sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(mul_p);

  // Next-state and operand latching; operands only change on an accept.
  always_comb begin
    state_d = state_q;
    da_d    = da_q;
    db_d    = db_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          da_d    = in_a;
          db_d    = in_b;
          state_d = S_LOAD;
        end
      end
      S_LOAD:    state_d = S_RUN;
      S_RUN:     if (mul_finish) state_d = S_ACCUM;
      S_ACCUM:   state_d = S_RELEASE;
      S_RELEASE: if (!mul_finish) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Accumulator update; clear during ACCUM restarts the sum from this product.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == S_ACCUM) begin
      if (clear) begin
        acc_d = ACC_W'(mul_p);
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_d = ovf_q | acc_sum[ACC_W];
      end
    end else if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      da_q    <= '0;
      db_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      da_q    <= da_d;
      db_q    <= db_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Control outputs are pure decodes of the state register.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mul_la    = (state_q == S_LOAD);
  assign mul_lb    = (state_q == S_LOAD);
  assign mul_s     = (state_q == S_RUN) || (state_q == S_ACCUM);
  assign mul_da    = da_q;
  assign mul_db    = db_q;
  assign acc       = acc_q;
  assign acc_count = cnt_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_accumulator
// Description : Self-checking bench for mac_accumulator. Two instances (72-bit
//               and 64-bit accumulators) share stimulus and a behavioural
//               multiplier; results are compared with an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_a, in_b;
  logic        clear;
  logic [63:0] mul_p;
  logic        mul_finish;

  logic        in_ready, busy, mul_la, mul_lb, mul_s, ovf;
  logic [31:0] mul_da, mul_db;
  logic [71:0] acc;
  logic [7:0]  acc_count;

  logic        in_ready64, busy64, mul_la64, mul_lb64, mul_s64, ovf64;
  logic [31:0] mul_da64, mul_db64;
  logic [63:0] acc64;
  logic [7:0]  acc_count64;

  always #5 clk = ~clk;

  mac_accumulator #(.N(32), .ACC_W(72), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .clear(clear), .mul_da(mul_da), .mul_db(mul_db),
    .mul_la(mul_la), .mul_lb(mul_lb), .mul_s(mul_s), .mul_p(mul_p),
    .mul_finish(mul_finish), .acc(acc), .acc_count(acc_count), .ovf(ovf),
    .busy(busy)
  );

  mac_accumulator #(.N(32), .ACC_W(64), .CNT_W(8)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_a(in_a), .in_b(in_b), .clear(clear), .mul_da(mul_da64), .mul_db(mul_db64),
    .mul_la(mul_la64), .mul_lb(mul_lb64), .mul_s(mul_s64), .mul_p(mul_p),
    .mul_finish(mul_finish), .acc(acc64), .acc_count(acc_count64), .ovf(ovf64),
    .busy(busy64)
  );

  // Behavioural multiplier: latency `lat` after start, Finish drops
  // `rel_lat` cycles after s is released; zero operand finishes at load.
  int          lat = 2;
  int          rel_lat = 0;
  logic [31:0] m_a, m_b;
  int          m_cnt, m_rel;

  always @(posedge clk) begin
    if (reset) begin
      mul_finish <= 1'b0;
      mul_p      <= '0;
      m_cnt      <= 0;
      m_rel      <= 0;
    end else if (mul_la && mul_lb) begin
      m_a   <= mul_da;
      m_b   <= mul_db;
      m_rel <= rel_lat;
      if (mul_db == 32'd0) begin
        mul_finish <= 1'b1;
        mul_p      <= '0;
      end else begin
        mul_finish <= 1'b0;
        m_cnt      <= lat;
      end
    end else if (mul_s && !mul_finish) begin
      if (m_cnt == 0) begin
        mul_finish <= 1'b1;
        mul_p      <= 64'(m_a) * 64'(m_b);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (!mul_s && mul_finish) begin
      if (m_rel == 0) mul_finish <= 1'b0;
      else            m_rel <= m_rel - 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain modular arithmetic on the products.
  logic [71:0] ref72;
  logic [63:0] ref64;
  int          refcnt;
  bit          refovf72, refovf64;

  task automatic model_zero();
    ref72 = '0; ref64 = '0; refcnt = 0; refovf72 = 0; refovf64 = 0;
  endtask

  task automatic model_op(input logic [31:0] a, input logic [31:0] b, input bit clr);
    logic [127:0] p;
    logic [127:0] s;
    p = 128'(a) * 128'(b);
    if (clr) begin
      ref72 = p[71:0]; ref64 = p[63:0]; refcnt = 1; refovf72 = 0; refovf64 = 0;
    end else begin
      s = 128'(ref72) + p;
      ref72 = s[71:0];
      if (s[72]) refovf72 = 1;
      s = 128'(ref64) + p;
      ref64 = s[63:0];
      if (s[64]) refovf64 = 1;
      refcnt = (refcnt == 255) ? 255 : refcnt + 1;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".acc72"},  128'(acc),         128'(ref72));
    chk({tag, ".acc64"},  128'(acc64),       128'(ref64));
    chk({tag, ".count"},  128'(acc_count),   128'(refcnt));
    chk({tag, ".ovf72"},  128'(ovf),         128'(refovf72));
    chk({tag, ".ovf64"},  128'(ovf64),       128'(refovf64));
  endtask

  // One full transaction; optionally asserts clear during the ACCUM cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit clr_accum,
                       output int la_cycles, output int ready_while_busy);
    bit sf_prev = 0;
    bit done_clr = 0;
    bit ok = 0;
    la_cycles = 0;
    ready_while_busy = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (clear) clear = 1'b0;
      if (mul_la && mul_lb) la_cycles++;
      if (busy && in_ready) ready_while_busy++;
      if (mul_s && mul_finish) begin
        if (sf_prev && clr_accum && !done_clr) begin
          clear = 1'b1;
          done_clr = 1;
        end
        sf_prev = 1;
      end else begin
        sf_prev = 0;
      end
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 128'(0), 128'(1));
    clear = 1'b0;
  endtask

  task automatic idle_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    model_zero();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [71:0] exp_acc;
    int          exp_cnt;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int la, rwb;
    vecs[0] = '{32'd3,          32'd5,          72'd15,                    1, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  72'hFFFF_FFFE_0000_0010,   2, 1'b0};
    vecs[2] = '{32'h0000_1234,  32'd0,          72'hFFFF_FFFE_0000_0010,   3, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    model_zero();

    chk("rst.acc",      128'(acc),       128'(0));
    chk("rst.count",    128'(acc_count), 128'(0));
    chk("rst.ovf",      128'(ovf),       128'(0));
    chk("rst.ready",    128'(in_ready),  128'(1));
    chk("rst.busy",     128'(busy),      128'(0));
    chk("rst.la_lb_s",  128'({mul_la, mul_lb, mul_s}), 128'(0));
    chk("rst.da_db",    128'({mul_da, mul_db}),        128'(0));

    // Directed vectors from a cleared accumulator.
    for (int i = 0; i < 3; i++) begin
      do_op(vecs[i].a, vecs[i].b, 1'b0, la, rwb);
      model_op(vecs[i].a, vecs[i].b, 1'b0);
      chk($sformatf("vec%0d.acc72", i), 128'(acc),       128'(vecs[i].exp_acc));
      chk($sformatf("vec%0d.acc64", i), 128'(acc64),     128'(vecs[i].exp_acc[63:0]));
      chk($sformatf("vec%0d.count", i), 128'(acc_count), 128'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d.ovf", i),   128'(ovf),       128'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d.la_pulse", i), 128'(la), 128'(1));
      chk($sformatf("vec%0d.ready_busy", i), 128'(rwb), 128'(0));
      chk($sformatf("vec%0d.ready_after", i), 128'(in_ready), 128'(1));
    end

    // Overflow on the 64-bit instance, carried into bit 64 on the 72-bit one.
    idle_clear();
    chk("clr1.acc", 128'(acc), 128'(0));
    chk("clr1.count", 128'(acc_count), 128'(0));
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, la, rwb);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, la, rwb);
    model_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    model_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("ovf.acc64",  128'(acc64), 128'(64'hFFFF_FFFC_0000_0002));
    chk("ovf.ovf64",  128'(ovf64), 128'(1));
    chk("ovf.acc72",  128'(acc),   128'(72'h1_FFFF_FFFC_0000_0002));
    chk("ovf.ovf72",  128'(ovf),   128'(0));
    idle_clear();
    chk("clr2.acc64", 128'(acc64), 128'(0));
    chk("clr2.ovf64", 128'(ovf64), 128'(0));

    // Clear during ACCUM replaces the sum with the current product.
    do_op(32'd10, 32'd10, 1'b0, la, rwb);
    model_op(32'd10, 32'd10, 1'b0);
    chk("pre.acc", 128'(acc), 128'(100));
    do_op(32'd7, 32'd6, 1'b1, la, rwb);
    model_op(32'd7, 32'd6, 1'b1);
    chk("accclr.acc",   128'(acc),       128'(42));
    chk("accclr.count", 128'(acc_count), 128'(1));

    // Reset in the middle of RUN.
    lat = 8;
    @(negedge clk);
    in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun.s", 128'(mul_s), 128'(1));
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    model_zero();
    chk("midrst.busy",  128'(busy),      128'(0));
    chk("midrst.ready", 128'(in_ready),  128'(1));
    chk("midrst.s",     128'(mul_s),     128'(0));
    chk("midrst.acc",   128'(acc),       128'(0));
    chk("midrst.count", 128'(acc_count), 128'(0));
    lat = 2;
    do_op(32'd2, 32'd2, 1'b0, la, rwb);
    model_op(32'd2, 32'd2, 1'b0);
    chk("post.acc", 128'(acc), 128'(4));
    chk_model("post");

    // Randomized transactions against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      bit clr;
      a = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      clr = ($urandom_range(0, 7) == 0);
      lat = $urandom_range(0, 4);
      rel_lat = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) idle_clear();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(a, b, clr, la, rwb);
      model_op(a, b, clr);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
